// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the 5-stage RV32I core.
//
// Holds the instruction memory (IMEM), the data memory (DMEM) and a small
// MMIO block (cycle counter, scratch register, tohost/exit register). A
// valid/ready loader fills IMEM while the core is held in reset. Once the
// load completes, the core is released.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pcF / instrF      fetch port: byte address in, instruction word out (comb)
//   dmem_we, dmem_addr, dmem_wdata / data_readM
//                     data port: word write at the clock edge, comb read
//   ld_valid, ld_data, ld_last / ld_ready
//                     program loader handshake (IMEM fill)
//   core_rst_n        registered active-low reset for the core
//   halted, exit_code tohost status
module mem_responder #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] data_readM,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        core_rst_n,
  output logic        halted,
  output logic [31:0] exit_code
);

  localparam int          IW  = $clog2(IMEM_WORDS);
  localparam int          DW  = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          core_rst_n_q;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [31:0]   exit_code_q, exit_code_d;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  // Address decode. Low two address bits are ignored (word access only).
  logic        fetch_in_imem;
  logic        data_in_dmem;
  logic        data_in_mmio;
  logic [13:0] mmio_word;
  logic        run;
  logic        ld_fire;
  logic        dmem_wr;
  logic        scratch_wr;
  logic        tohost_wr;
  logic        unused_bits;

  assign fetch_in_imem = (pcF[31:IW+2] == '0);
  assign data_in_dmem  = (dmem_addr[31:DW+2] == '0);
  assign data_in_mmio  = (dmem_addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_word     = dmem_addr[15:2];
  assign unused_bits   = ^{pcF[1:0], dmem_addr[1:0], MMIO_BASE[15:0]};

  assign run        = (state_q == S_RUN);
  assign ld_fire    = (state_q == S_LOAD) && ld_valid;
  // Writes only take effect in RUN; in LOAD and HALT they are dropped.
  assign dmem_wr    = run && dmem_we && data_in_dmem;
  assign scratch_wr = run && dmem_we && data_in_mmio && (mmio_word == 14'd1);
  assign tohost_wr  = run && dmem_we && data_in_mmio && (mmio_word == 14'd2);

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cycle_d     = cycle_q;
    scratch_d   = scratch_q;
    exit_code_d = exit_code_q;
    ld_ready    = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_fire) begin
          ptr_d = ptr_q + 1'b1;
          // The final IMEM slot ends the load even without ld_last (no wrap).
          if (ld_last || (ptr_q == IW'(IMEM_WORDS - 1))) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cycle_d = cycle_q + 32'd1;
        if (scratch_wr) begin
          scratch_d = dmem_wdata;
        end
        if (tohost_wr) begin
          exit_code_d = dmem_wdata;
          state_d     = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      ptr_q        <= '0;
      core_rst_n_q <= 1'b0;
      cycle_q      <= '0;
      scratch_q    <= '0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      // Registered from the current state so the core leaves reset one cycle
      // after RUN begins and re-enters reset one cycle after HALT begins.
      core_rst_n_q <= (state_q == S_RUN);
      cycle_q      <= cycle_d;
      scratch_q    <= scratch_d;
      exit_code_q  <= exit_code_d;
    end
  end

  // Memory arrays are not cleared by reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      imem[ptr_q] <= ld_data;
    end
    if (dmem_wr) begin
      dmem[dmem_addr[DW+1:2]] <= dmem_wdata;
    end
  end

  // Combinational read ports; a same-cycle write is seen only after the edge.
  always_comb begin
    instrF = NOP;
    if (run && fetch_in_imem) begin
      instrF = imem[pcF[IW+1:2]];
    end
  end

  always_comb begin
    data_readM = '0;
    if (run) begin
      if (data_in_dmem) begin
        data_readM = dmem[dmem_addr[DW+1:2]];
      end else if (data_in_mmio) begin
        case (mmio_word)
          14'd0:   data_readM = cycle_q;
          14'd1:   data_readM = scratch_q;
          14'd2:   data_readM = exit_code_q;
          default: data_readM = '0;
        endcase
      end
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign halted     = (state_q == S_HALT);
  assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [31:0] MB  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          IMW = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] data_readM;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        core_rst_n;
  logic        halted;
  logic [31:0] exit_code;

  always #5 clk = ~clk;

  mem_responder #(
    .IMEM_WORDS(IMW),
    .DMEM_WORDS(1024),
    .MMIO_BASE (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pcF       (pcF),
    .instrF    (instrF),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .data_readM(data_readM),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .core_rst_n(core_rst_n),
    .halted    (halted),
    .exit_code (exit_code)
  );

  logic [31:0] exp_q[$];
  logic [31:0] obs;
  logic [31:0] exp_v;
  int          checks = 0;
  int          errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'h1000_0000 + 32'(k) * 32'd7;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pcF = 32'h0; dmem_we = 1'b0; dmem_addr = MB + 32'h4;
    dmem_wdata = 32'h0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(NOP); exp_q.push_back(32'd0);
    repeat (3) cyc();
    #1;
    obs = 32'(ld_ready); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_ld_ready got=%h want=%h", obs, exp_v); end
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_core_rst_n got=%h want=%h", obs, exp_v); end
    obs = 32'(halted); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_halted got=%h want=%h", obs, exp_v); end
    obs = exit_code; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_exit_code got=%h want=%h", obs, exp_v); end
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_instr_nop got=%h want=%h", obs, exp_v); end
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_data_zero got=%h want=%h", obs, exp_v); end
    $display("reset applied and sampled");
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_load_basic();
    logic [31:0] words [4];
    words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113;
    words[2] = 32'h0020_81B3; words[3] = 32'h0000_006F;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      $display("load word %0d = %h", i, words[i]);
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    obs = 32'(ld_ready); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load_ready_drop got=%h want=%h", obs, exp_v); end
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load_core_rst_still_low got=%h want=%h", obs, exp_v); end
    cyc();
    exp_q.push_back(32'd1);
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load_core_rst_release got=%h want=%h", obs, exp_v); end
    pcF = 32'h8; exp_q.push_back(words[2]); #1;
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fetch_0x8 got=%h want=%h", obs, exp_v); end
    pcF = 32'h7; exp_q.push_back(words[1]); #1;
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fetch_low_bits got=%h want=%h", obs, exp_v); end
    pcF = 32'h100; exp_q.push_back(NOP); #1;
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fetch_out_of_range got=%h want=%h", obs, exp_v); end
    pcF = 32'h0;
  endtask

  task automatic test_dmem();
    dmem_addr = 32'h40; dmem_we = 1'b1; dmem_wdata = 32'h1111_1111;
    cyc();
    dmem_wdata = 32'hDEAD_BEEF; exp_q.push_back(32'h1111_1111); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dmem_same_cycle_old got=%h want=%h", obs, exp_v); end
    cyc();
    dmem_we = 1'b0; exp_q.push_back(32'hDEAD_BEEF); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dmem_write_visible got=%h want=%h", obs, exp_v); end
    dmem_addr = 32'h43; exp_q.push_back(32'hDEAD_BEEF); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dmem_low_bits got=%h want=%h", obs, exp_v); end
    dmem_addr = 32'h4000; dmem_we = 1'b1; dmem_wdata = 32'hCAFE_F00D;
    $display("write out-of-range 0x4000");
    cyc();
    dmem_we = 1'b0; exp_q.push_back(32'h0); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dmem_out_of_range got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_mmio();
    logic [31:0] a;
    logic [31:0] c;
    dmem_addr = MB + 32'h4; dmem_we = 1'b1; dmem_wdata = 32'h1234_5678;
    exp_q.push_back(32'h0); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL scratch_same_cycle_old got=%h want=%h", obs, exp_v); end
    cyc();
    dmem_we = 1'b0; exp_q.push_back(32'h1234_5678); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL scratch_readback got=%h want=%h", obs, exp_v); end
    dmem_addr = MB; #1;
    a = data_readM;
    exp_q.push_back(32'd10);
    repeat (10) cyc();
    obs = data_readM - a; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL counter_delta got=%h want=%h", obs, exp_v); end
    dmem_we = 1'b1; dmem_wdata = 32'h0; #1;
    c = data_readM;
    exp_q.push_back(c + 32'd1);
    cyc();
    dmem_we = 1'b0;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL counter_write_ignored got=%h want=%h", obs, exp_v); end
    dmem_addr = MB + 32'hC; exp_q.push_back(32'h0); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mmio_other_offset got=%h want=%h", obs, exp_v); end
    dmem_addr = MB + 32'h1_0004; exp_q.push_back(32'h0); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL outside_window got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_halt();
    dmem_addr = MB + 32'h8; dmem_we = 1'b1; dmem_wdata = 32'h0000_002A;
    exp_q.push_back(32'd0); #1;
    obs = 32'(halted); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_before_edge got=%h want=%h", obs, exp_v); end
    $display("write tohost 0x2A");
    cyc();
    dmem_we = 1'b0;
    exp_q.push_back(32'd1); exp_q.push_back(32'h2A); exp_q.push_back(32'd1);
    #1;
    obs = 32'(halted); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halted_set got=%h want=%h", obs, exp_v); end
    obs = exit_code; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL exit_code got=%h want=%h", obs, exp_v); end
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_core_rst_lag got=%h want=%h", obs, exp_v); end
    cyc();
    exp_q.push_back(32'd0);
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_core_rst_low got=%h want=%h", obs, exp_v); end
    // Writes in HALT must be dropped: DMEM here, tohost below.
    dmem_addr = 32'h40; dmem_we = 1'b1; dmem_wdata = 32'h5555_5555;
    cyc();
    dmem_addr = MB + 32'h8; dmem_wdata = 32'h0000_0099;
    cyc();
    dmem_we = 1'b0; dmem_addr = 32'h40; pcF = 32'h8;
    exp_q.push_back(32'h2A); exp_q.push_back(32'h0); exp_q.push_back(NOP);
    #1;
    obs = exit_code; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_tohost_dropped got=%h want=%h", obs, exp_v); end
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_data_zero got=%h want=%h", obs, exp_v); end
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_instr_nop got=%h want=%h", obs, exp_v); end
    pcF = 32'h0;
  endtask

  task automatic test_back_to_back();
    int idx [5];
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < IMW; i++) begin
      if (i == 20) begin
        ld_valid = 1'b0; ld_data = 32'hBAD0_BAD0;
        repeat (3) cyc();
        exp_q.push_back(32'd1);
        obs = 32'(ld_ready); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pause_ready got=%h want=%h", obs, exp_v); end
      end
      ld_valid = 1'b1; ld_data = pat(i); ld_last = 1'b0;
      if (i == IMW - 1) begin
        exp_q.push_back(32'd1); #1;
        obs = 32'(ld_ready); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stream_ready_before_last got=%h want=%h", obs, exp_v); end
      end
      cyc();
    end
    ld_valid = 1'b0;
    $display("streamed %0d words", IMW);
    exp_q.push_back(32'd0); #1;
    obs = 32'(ld_ready); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stream_full_ends_load got=%h want=%h", obs, exp_v); end
    cyc();
    exp_q.push_back(32'd1);
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stream_core_release got=%h want=%h", obs, exp_v); end
    idx[0] = 0; idx[1] = 19; idx[2] = 20; idx[3] = 21; idx[4] = IMW - 1;
    for (int j = 0; j < 5; j++) begin
      pcF = 32'(idx[j]) * 32'd4; exp_q.push_back(pat(idx[j])); #1;
      obs = instrF; exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stream_word_%0d got=%h want=%h", idx[j], obs, exp_v); end
    end
    pcF = 32'h0;
    dmem_addr = 32'h40; exp_q.push_back(32'hDEAD_BEEF); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dmem_kept_halt_write_dropped got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_run();
    logic found;
    found = 1'b0;
    dmem_addr = MB + 32'h4; dmem_we = 1'b1; dmem_wdata = 32'h0000_0077;
    cyc();
    dmem_we = 1'b0; dmem_addr = MB;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (data_readM == 32'd57) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    exp_q.push_back(32'd1);
    obs = 32'(found); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL counter_reach_57 got=%h want=%h", obs, exp_v); end
    rst_n = 1'b0;
    $display("async reset at counter 57");
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    obs = 32'(ld_ready); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrun_reset_load got=%h want=%h", obs, exp_v); end
    obs = 32'(core_rst_n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrun_reset_core got=%h want=%h", obs, exp_v); end
    obs = exit_code; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrun_reset_exit got=%h want=%h", obs, exp_v); end
    cyc();
    rst_n = 1'b1;
    cyc();
    ld_valid = 1'b1; ld_data = 32'h0000_0073; ld_last = 1'b1;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    dmem_addr = MB; exp_q.push_back(32'd0); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrun_counter_cleared got=%h want=%h", obs, exp_v); end
    dmem_addr = MB + 32'h4; exp_q.push_back(32'd0); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrun_scratch_cleared got=%h want=%h", obs, exp_v); end
    dmem_addr = 32'h40; exp_q.push_back(32'hDEAD_BEEF); #1;
    obs = data_readM; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midrun_dmem_kept got=%h want=%h", obs, exp_v); end
    pcF = 32'h0; exp_q.push_back(32'h0000_0073); #1;
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reload_word0 got=%h want=%h", obs, exp_v); end
    pcF = 32'h4; exp_q.push_back(pat(1)); #1;
    obs = instrF; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reload_old_word1 got=%h want=%h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_dmem();
    test_mmio();
    test_halt();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
